// File: rtl/icache_dnreq_sched_if.sv
// ============================================================================
// Module   : icache_dnreq_sched_if
// Brief    : Request/downstream handshake bundle for the ICache downstream scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface icache_dnreq_sched_if #(
    parameter int PLD_W = 64,
    parameter int ID_W  = 3
);
    logic             dmd_req_vld;
    logic             dmd_req_rdy;
    logic [PLD_W-1:0] dmd_req_pld;
    logic             pf_req_vld;
    logic             pf_req_rdy;
    logic [PLD_W-1:0] pf_req_pld;
    logic             downstream_txreq_vld;
    logic             downstream_txreq_rdy;
    logic [PLD_W-1:0] downstream_txreq_pld;
    logic [ID_W-1:0]  downstream_txreq_entry_id;
    logic             downstream_txreq_is_pf;
    logic             downstream_rxdat_vld;
    logic             downstream_rxdat_rdy;
    logic [ID_W-1:0]  downstream_rxdat_entry_id;
    logic             downstream_rxdat_last;

    modport master (
        output dmd_req_vld, dmd_req_pld, pf_req_vld, pf_req_pld,
               downstream_txreq_rdy, downstream_rxdat_vld,
               downstream_rxdat_entry_id, downstream_rxdat_last,
        input  dmd_req_rdy, pf_req_rdy, downstream_txreq_vld,
               downstream_txreq_pld, downstream_txreq_entry_id,
               downstream_txreq_is_pf, downstream_rxdat_rdy
    );

    modport slave (
        input  dmd_req_vld, dmd_req_pld, pf_req_vld, pf_req_pld,
               downstream_txreq_rdy, downstream_rxdat_vld,
               downstream_rxdat_entry_id, downstream_rxdat_last,
        output dmd_req_rdy, pf_req_rdy, downstream_txreq_vld,
               downstream_txreq_pld, downstream_txreq_entry_id,
               downstream_txreq_is_pf, downstream_rxdat_rdy
    );
endinterface

`default_nettype wire

// File: rtl/icache_dnreq_sched.sv
// ============================================================================
// Module   : icache_dnreq_sched
// Brief    : Arbitrates demand/prefetch misses onto downstream txreq, tracks entry IDs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_dnreq_sched #(
    parameter int ENTRY_NUM  = 8,
    parameter int ID_W       = 3,
    parameter int PLD_W      = 64,
    parameter int PF_RSV     = 2,
    parameter int STARVE_LIM = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               prefetch_enable,
    icache_dnreq_sched_if.slave     bus,
    output logic [ID_W:0]           outstanding_cnt,
    output logic                    sched_idle
);
    localparam int             STV_W        = $clog2(STARVE_LIM + 1);
    localparam logic [ID_W:0]  c_ENTRY_NUM  = (ID_W+1)'(ENTRY_NUM);
    localparam logic [ID_W:0]  c_PF_RSV     = (ID_W+1)'(PF_RSV);
    localparam logic [STV_W-1:0] c_STARVE_LIM = STV_W'(STARVE_LIM);

    logic [ENTRY_NUM-1:0] busy_q, busy_d;
    logic [ID_W:0]        cnt_q, cnt_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 txreq_vld_q;
    logic [PLD_W-1:0]     txreq_pld_q;
    logic [ID_W-1:0]      txreq_id_q;
    logic                 txreq_is_pf_q;
    logic                 rxdat_rdy_q;

    logic [ID_W:0]        w_free_cnt;
    logic                 w_load_ok, w_dmd_ok, w_pf_ok, w_force_pf;
    logic                 w_dmd_fire, w_pf_fire, w_fire, w_rel;
    logic [ID_W-1:0]      w_alloc_id;

    // Grant uses only registered occupancy, so a freed entry is visible next cycle.
    assign w_free_cnt = c_ENTRY_NUM - cnt_q;
    assign w_load_ok  = !txreq_vld_q || bus.downstream_txreq_rdy;
    assign w_dmd_ok   = w_load_ok && (w_free_cnt != '0);
    assign w_pf_ok    = w_load_ok && prefetch_enable && (w_free_cnt > c_PF_RSV);
    assign w_force_pf = (starve_q >= c_STARVE_LIM) && bus.pf_req_vld && w_pf_ok;

    assign bus.dmd_req_rdy = w_dmd_ok && !w_force_pf;
    assign bus.pf_req_rdy  = w_pf_ok && (!bus.dmd_req_vld || w_force_pf);

    assign w_dmd_fire = bus.dmd_req_vld && bus.dmd_req_rdy;
    assign w_pf_fire  = bus.pf_req_vld && bus.pf_req_rdy;
    assign w_fire     = w_dmd_fire || w_pf_fire;
    assign w_rel      = bus.downstream_rxdat_vld && bus.downstream_rxdat_last &&
                        busy_q[bus.downstream_rxdat_entry_id];

    always_comb begin
        w_alloc_id = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) w_alloc_id = ID_W'(i);
        end
    end

    // Alloc index comes from busy_q, so it can never collide with a same-cycle release.
    always_comb begin
        busy_d = busy_q;
        if (w_rel)  busy_d[bus.downstream_rxdat_entry_id] = 1'b0;
        if (w_fire) busy_d[w_alloc_id] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_fire && !w_rel)      cnt_d = cnt_q + (ID_W+1)'(1);
        else if (!w_fire && w_rel) cnt_d = cnt_q - (ID_W+1)'(1);
    end

    always_comb begin
        starve_d = starve_q;
        if (w_pf_fire || !bus.pf_req_vld)
            starve_d = '0;
        else if (w_dmd_fire && (starve_q < c_STARVE_LIM))
            starve_d = starve_q + STV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_q        <= '0;
            cnt_q         <= '0;
            starve_q      <= '0;
            txreq_vld_q   <= 1'b0;
            txreq_pld_q   <= '0;
            txreq_id_q    <= '0;
            txreq_is_pf_q <= 1'b0;
            rxdat_rdy_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            rxdat_rdy_q <= 1'b1;
            if (w_load_ok) begin
                txreq_vld_q <= w_fire;
                if (w_fire) begin
                    txreq_pld_q   <= w_dmd_fire ? bus.dmd_req_pld : bus.pf_req_pld;
                    txreq_id_q    <= w_alloc_id;
                    txreq_is_pf_q <= w_pf_fire;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && bus.downstream_rxdat_vld && bus.downstream_rxdat_last) begin
            assert (busy_q[bus.downstream_rxdat_entry_id])
                else $error("release of non-busy entry %0d", bus.downstream_rxdat_entry_id);
        end
    end

    assign bus.downstream_txreq_vld      = txreq_vld_q;
    assign bus.downstream_txreq_pld      = txreq_pld_q;
    assign bus.downstream_txreq_entry_id = txreq_id_q;
    assign bus.downstream_txreq_is_pf    = txreq_is_pf_q;
    assign bus.downstream_rxdat_rdy      = rxdat_rdy_q;
    assign outstanding_cnt               = cnt_q;
    assign sched_idle                    = (cnt_q == '0) && !txreq_vld_q;

endmodule

`default_nettype wire

// File: doc/icache_dnreq_sched.md
Name: icache_dnreq_sched

Overview:
- Schedules ICache downstream read requests onto the single downstream_txreq channel.
- Arbitrates between demand-miss requests from the MSHR and prefetch requests from the prefetcher.
- Allocates an outstanding-transaction entry ID per request and frees it on the last returning data beat.
- Sits between the MSHR/prefetch front end and the downstream interface. Replaces the direct MSHR-to-txreq path.

Parameters:
- ENTRY_NUM, 8: number of outstanding downstream transactions (entry IDs 0..ENTRY_NUM-1).
- ID_W, 3: entry ID width, equal to clog2(ENTRY_NUM).
- PLD_W, 64: request payload width (packed pc_req_t).
- PF_RSV, 2: entries reserved for demand; prefetch is granted only if free_cnt > PF_RSV.
- STARVE_LIM, 4: number of consecutive demand grants allowed while a prefetch waits before one prefetch grant is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-high
- prefetch_enable  in  1  gates prefetch grants
- dmd_req_vld  in  1  demand request valid
- dmd_req_rdy  out  1  demand request accepted
- dmd_req_pld  in  PLD_W  demand payload
- pf_req_vld  in  1  prefetch request valid
- pf_req_rdy  out  1  prefetch request accepted
- pf_req_pld  in  PLD_W  prefetch payload
- downstream_txreq_vld  out  1  request to downstream
- downstream_txreq_rdy  in  1  downstream accepts
- downstream_txreq_pld  out  PLD_W  forwarded payload
- downstream_txreq_entry_id  out  ID_W  allocated entry ID
- downstream_txreq_is_pf  out  1  1 = prefetch-originated
- downstream_rxdat_vld  in  1  data beat returning
- downstream_rxdat_rdy  out  1  always 1 after reset
- downstream_rxdat_entry_id  in  ID_W  entry of returning beat
- downstream_rxdat_last  in  1  final beat of the transaction
- outstanding_cnt  out  ID_W+1  number of allocated entries
- sched_idle  out  1  no entries allocated and output stage empty

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - Outputs: txreq_vld=0, txreq_pld/entry_id/is_pf=0, outstanding_cnt=0, sched_idle=1, rxdat_rdy=0 during reset and 1 otherwise.
  - State: all entries free, starvation counter=0.
  - Reset mid-transaction drops all state. Downstream is reset in the same domain.
- Output stage: a single register.
  - load_ok = !txreq_vld || txreq_rdy.
  - The stage holds pld, entry_id and is_pf stable while vld=1 and rdy=0.
- Grant, combinational from registered state:
  - dmd_ok = load_ok && free_cnt>0.
  - pf_ok = load_ok && prefetch_enable && free_cnt>PF_RSV.
  - force_pf = starve_cnt>=STARVE_LIM && pf_req_vld && pf_ok.
  - dmd_req_rdy = dmd_ok && !force_pf.
  - pf_req_rdy = pf_ok && (!dmd_req_vld || force_pf).
  - At most one of dmd/pf fires per cycle.
- Starvation counter:
  - Increments on a demand fire when pf_req_vld=1. Saturates at STARVE_LIM.
  - Clears on a prefetch fire, or on any cycle with pf_req_vld=0.
- Latency: a fire in cycle N gives txreq_vld=1 in cycle N+1. Back-to-back fires give one request per cycle when txreq_rdy=1.
- Allocation:
  - On fire, take the lowest-index free entry and mark it busy.
  - Its ID goes to txreq_entry_id. is_pf is set to 1 for a prefetch fire.
- Release:
  - rxdat_vld && rxdat_last frees rxdat_entry_id. Non-last beats change no state.
  - A freed entry becomes allocatable from the next cycle; free_cnt used by grant is registered.
- Simultaneous allocate and free in the same cycle: both apply, and outstanding_cnt is unchanged. A different index is allocated, because the freed index was still busy when the free entry was chosen.
- Release of an entry that is not busy is ignored. This is a simulation assertion error.
- Full (free_cnt=0): both rdy=0. Entries already in the output stage still drain.
- Free_cnt at or below PF_RSV: only demand is granted.
- prefetch_enable deasserting blocks new prefetch grants only. A prefetch already in the output stage is still sent and its entry is tracked normally.
- outstanding_cnt is a registered count of busy entries, in the range 0..ENTRY_NUM.
- sched_idle = outstanding_cnt==0 && !txreq_vld.

Test Plan:
- Demand only, txreq_rdy=1, 8 requests on consecutive cycles:
  - entry_ids 0..7 appear one per cycle, each 1 cycle after fire.
  - outstanding_cnt reaches 8 and the 9th request sees dmd_req_rdy=0.
- Backpressure: txreq_rdy=0 for 5 cycles with one request loaded:
  - txreq_vld/pld/entry_id are held stable.
  - both rdy=0 until txreq_rdy=1.
- Reservation, PF_RSV=2: allocate 6 demand entries, then pf_req_vld=1:
  - pf_req_rdy=0.
  - Return the last beat for entry 3; on the next cycle pf_req_rdy=1, the prefetch gets entry_id=3, and is_pf=1.
- Starvation, STARVE_LIM=4: dmd_req_vld and pf_req_vld held high:
  - grant order is D,D,D,D,P,D,D,D,D,P.
  - With prefetch_enable=0, the order is all D.
- Same-cycle alloc and free with entries 0..6 busy: demand fires while rxdat_last frees entry 2:
  - the new entry is 7 and outstanding_cnt stays 7.
  - The next fire gets entry 2.
- Reset mid-operation with 5 entries busy and txreq_vld=1, rst_n=1 for one cycle:
  - next cycle txreq_vld=0, outstanding_cnt=0, sched_idle=1.
  - The first post-reset fire gets entry_id=0.
